// File: rtl/jtframe_rom_slot.sv
// ROM port responder: serves CPU reads from a 2-entry word cache and fills
// misses with one SDRAM request at a time.
module jtframe_rom_slot #(
  parameter int AW = 18,
  parameter int DW = 8,
  localparam int LW = (DW == 8) ? 2 : (DW == 16) ? 1 : 0
) (
  input  logic             rst_n,
  input  logic             clk,
  input  logic             clr,
  input  logic [AW-1:0]    addr,
  input  logic             addr_ok,
  output logic             data_ok,
  output logic [DW-1:0]    dout,
  output logic [AW-LW-1:0] sdram_addr,
  output logic             sdram_req,
  input  logic             sdram_ack,
  input  logic             sdram_dst,
  input  logic [31:0]      sdram_din
);

  localparam int TW = AW - LW;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT
  } state_t;

  state_t          st_q, st_d;
  logic [1:0]      valid_q, valid_d;
  logic [TW-1:0]   tag_q [2];
  logic [31:0]     data_q [2];
  logic            lru_q, lru_d;
  logic            tgt_q, tgt_d;
  logic            drop_q, drop_d;
  logic            req_q, req_d;
  logic [TW-1:0]   saddr_q, saddr_d;
  logic            fill_en;

  logic [TW-1:0]   atag;
  logic            hit0, hit1, hit, hway;
  logic [31:0]     hit_word;
  logic [1:0]      lane;
  logic [4:0]      shamt;

  assign atag = addr[AW-1:LW];
  assign hit0 = valid_q[0] && (tag_q[0] == atag);
  assign hit1 = valid_q[1] && (tag_q[1] == atag);
  assign hit  = addr_ok && (hit0 || hit1);
  assign hway = !hit0;
  assign hit_word = hit0 ? data_q[0] : data_q[1];

  generate
    if (LW > 0) begin : g_lane
      assign lane = 2'(addr[LW-1:0]);
    end else begin : g_nolane
      assign lane = 2'd0;
    end
  endgenerate

  // Little-endian lane pick inside the 32-bit word
  assign shamt   = 5'(lane) * 5'(DW);
  assign data_ok = hit;
  assign dout    = hit ? hit_word[shamt +: DW] : '0;

  assign sdram_req  = req_q;
  assign sdram_addr = saddr_q;

  always_comb begin
    st_d    = st_q;
    valid_d = valid_q;
    lru_d   = lru_q;
    tgt_d   = tgt_q;
    drop_d  = drop_q;
    req_d   = req_q;
    saddr_d = saddr_q;
    fill_en = 1'b0;

    if (hit) lru_d = !hway;

    case (st_q)
      ST_IDLE: begin
        drop_d = 1'b0;
        if (addr_ok && !hit && !clr) begin
          saddr_d = atag;
          req_d   = 1'b1;
          tgt_d   = lru_q;
          st_d    = ST_REQ;
        end
      end
      ST_REQ: begin
        drop_d = drop_q || clr;
        if (sdram_ack) begin
          req_d = 1'b0;
          if (sdram_dst) begin
            fill_en = 1'b1;
            st_d    = ST_IDLE;
          end else begin
            st_d = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        drop_d = drop_q || clr;
        if (sdram_dst) begin
          fill_en = 1'b1;
          st_d    = ST_IDLE;
        end
      end
      default: st_d = ST_IDLE;
    endcase

    // A clr seen at any point of the request discards the data it returns
    if (fill_en) begin
      drop_d = 1'b0;
      lru_d  = !tgt_q;
    end
    if (clr) valid_d = 2'b00;
    if (fill_en && !(drop_q || clr)) valid_d[tgt_q] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q    <= ST_IDLE;
      valid_q <= 2'b00;
      lru_q   <= 1'b0;
      tgt_q   <= 1'b0;
      drop_q  <= 1'b0;
      req_q   <= 1'b0;
      saddr_q <= '0;
    end else begin
      st_q    <= st_d;
      valid_q <= valid_d;
      lru_q   <= lru_d;
      tgt_q   <= tgt_d;
      drop_q  <= drop_d;
      req_q   <= req_d;
      saddr_q <= saddr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (fill_en) begin
      tag_q[tgt_q]  <= saddr_q;
      data_q[tgt_q] <= sdram_din;
    end
  end

endmodule
